// File: rtl/simd_cell_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : simd_cell_pkg
//  Description : Shared defaults, lane-count derivation and lane operand
//                typedefs for the simd_cell temporal multiplier array.
//  Revision    : 1.0 - initial release
// ============================================================================
package simd_cell_pkg;

   localparam int DEF_DIM_A        = 9;
   localparam int DEF_DIM_C        = 9;
   localparam int DEF_INPUT_WIDTH  = 4;
   localparam int DEF_WEIGHT_WIDTH = 4;
   localparam int DEF_ACC_WIDTH    = 8;

   // Lane operand types at the default widths.
   typedef logic [DEF_INPUT_WIDTH-1:0]  input_lane_t;
   typedef logic [DEF_WEIGHT_WIDTH-1:0] weight_lane_t;
   typedef logic [DEF_ACC_WIDTH-1:0]    acc_lane_t;

   // One multiplier lane per input lane.
   function automatic int dim_mult(input int dim_a);
      return dim_a;
   endfunction

endpackage : simd_cell_pkg
`default_nettype wire

// File: rtl/simd_cell_tlut_lane.sv
`default_nettype none
// ============================================================================
//  Module      : tlut_lane
//  Description : One temporal unary multiplier lane. The input operand is
//                loaded as a down-counter; every step cycle with a non-zero
//                count adds the weight into the accumulator, so the product
//                forms over a pass without any multiplier cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module tlut_lane #(
   parameter int INPUT_WIDTH  = 4,
   parameter int WEIGHT_WIDTH = 4,
   parameter int ACC_WIDTH    = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_i,
   input  logic                    step_i,
   input  logic [INPUT_WIDTH-1:0]  opnd_i,
   input  logic [WEIGHT_WIDTH-1:0] wt_i,
   output logic [ACC_WIDTH-1:0]    acc_next_o
);

   logic [INPUT_WIDTH-1:0]  rem_q, rem_d;
   logic [WEIGHT_WIDTH-1:0] w_q,   w_d;
   logic [ACC_WIDTH-1:0]    acc_q, acc_d;

   // Next-state: load operands at pass start, else one unary step while count remains.
   always_comb begin
      rem_d = rem_q;
      w_d   = w_q;
      acc_d = acc_q;
      if (load_i) begin
         rem_d = opnd_i;
         w_d   = wt_i;
         acc_d = '0;
      end else if (step_i && (rem_q != '0)) begin
         acc_d = acc_q + ACC_WIDTH'(w_q);
         rem_d = rem_q - INPUT_WIDTH'(1);
      end
   end

   // Lane state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_q <= '0;
         w_q   <= '0;
         acc_q <= '0;
      end else begin
         rem_q <= rem_d;
         w_q   <= w_d;
         acc_q <= acc_d;
      end
   end

   // Exposing the next value lets the top capture the final add of a pass.
   assign acc_next_o = acc_d;

endmodule : tlut_lane
`default_nettype wire

// File: rtl/simd_cell.sv
`default_nettype none
// ============================================================================
//  Module      : simd_cell
//  Description : DIM_A-lane unsigned SIMD multiplier built from temporal
//                unary lanes. A shared phase counter sequences a pass of
//                2^INPUT_WIDTH cycles: load at phase 0, accumulate at phases
//                1..max, capture products on the last phase edge.
//                Optional macro SIMD_CELL_ADDER_TREE_EN adds a dot_sum output
//                (balanced pairwise adder tree over all lane products).
//  Revision    : 1.0 - initial release
// ============================================================================
module simd_cell
   import simd_cell_pkg::*;
#(
   parameter int  DIM_A        = DEF_DIM_A,
   parameter int  DIM_C        = DEF_DIM_C,
   parameter int  INPUT_WIDTH  = DEF_INPUT_WIDTH,
   parameter int  WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
   parameter int  ACC_WIDTH    = DEF_ACC_WIDTH,
   localparam int DIM_MULT     = dim_mult(DIM_A)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 enable,
   input  logic [DIM_A-1:0][INPUT_WIDTH-1:0]    input_bin,
   input  logic [DIM_C-1:0][WEIGHT_WIDTH-1:0]   weight_bin,
   output logic [DIM_MULT-1:0][ACC_WIDTH-1:0]   product_acc,
   output logic                                 product_valid
`ifdef SIMD_CELL_ADDER_TREE_EN
   ,
   output logic [ACC_WIDTH+$clog2(DIM_MULT)-1:0] dot_sum
`endif
);

   localparam logic [INPUT_WIDTH-1:0] c_CNT_LAST = '1;

   if (DIM_C != DIM_A) begin : g_dim_mismatch
      $error("simd_cell: DIM_C must equal DIM_A");
   end

   logic [INPUT_WIDTH-1:0]              cnt_q, cnt_d;
   logic [DIM_MULT-1:0][ACC_WIDTH-1:0]  product_acc_q, product_acc_d;
   logic                                product_valid_q, product_valid_d;
   logic                                w_load;
   logic                                w_step;
   logic                                w_capture;
   logic [DIM_MULT-1:0][ACC_WIDTH-1:0]  w_lane_next;

   assign w_load    = enable && (cnt_q == '0);
   assign w_step    = enable && (cnt_q != '0);
   assign w_capture = enable && (cnt_q == c_CNT_LAST);

   for (genvar k = 0; k < DIM_MULT; k++) begin : g_lane
      tlut_lane #(
         .INPUT_WIDTH  (INPUT_WIDTH),
         .WEIGHT_WIDTH (WEIGHT_WIDTH),
         .ACC_WIDTH    (ACC_WIDTH)
      ) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .load_i     (w_load),
         .step_i     (w_step),
         .opnd_i     (input_bin[k]),
         .wt_i       (weight_bin[k]),
         .acc_next_o (w_lane_next[k])
      );
   end

   // Phase counter advances while enabled and restarts from load when disabled;
   // products are captured only when a full pass reaches its last phase.
   always_comb begin
      cnt_d           = enable ? cnt_q + INPUT_WIDTH'(1) : '0;
      product_acc_d   = w_capture ? w_lane_next : product_acc_q;
      product_valid_d = w_capture;
   end

   // Shared control and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q           <= '0;
         product_acc_q   <= '0;
         product_valid_q <= 1'b0;
      end else begin
         cnt_q           <= cnt_d;
         product_acc_q   <= product_acc_d;
         product_valid_q <= product_valid_d;
      end
   end

   assign product_acc   = product_acc_q;
   assign product_valid = product_valid_q;

`ifdef SIMD_CELL_ADDER_TREE_EN
   localparam int TREE_LVLS   = $clog2(DIM_MULT);
   localparam int TREE_LEAVES = 1 << TREE_LVLS;
   localparam int SUM_WIDTH   = ACC_WIDTH + TREE_LVLS;

   // Heap-ordered tree: node k sums children 2k+1 and 2k+2; leaves start at
   // TREE_LEAVES-1, padded with zeros up to a power of two.
   logic [SUM_WIDTH-1:0] w_node [2*TREE_LEAVES-1];
   logic [SUM_WIDTH-1:0] dot_sum_q, dot_sum_d;

   for (genvar k = 0; k < TREE_LEAVES; k++) begin : g_leaf
      if (k < DIM_MULT) begin : g_real
         assign w_node[TREE_LEAVES-1+k] = SUM_WIDTH'(w_lane_next[k]);
      end else begin : g_pad
         assign w_node[TREE_LEAVES-1+k] = '0;
      end
   end

   for (genvar k = 0; k < TREE_LEAVES-1; k++) begin : g_node
      assign w_node[k] = w_node[2*k+1] + w_node[2*k+2];
   end

   // The sum is taken over the same values being captured, so it lands with product_valid.
   always_comb begin
      dot_sum_d = w_capture ? w_node[0] : dot_sum_q;
   end

   // Dot-product result register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dot_sum_q <= '0;
      end else begin
         dot_sum_q <= dot_sum_d;
      end
   end

   assign dot_sum = dot_sum_q;
`endif

endmodule : simd_cell
`default_nettype wire

// File: tb/tb_simd_cell.sv
`default_nettype none
// ============================================================================
//  Module      : tb_simd_cell
//  Description : Self-checking bench for simd_cell at default parameters.
//                A pass-level model predicts products as plain input*weight
//                mod 256 per lane, checked every cycle; directed scenarios
//                add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_cell;

   localparam int N = 9;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               enable = 1'b0;
   logic [N-1:0][3:0]  input_bin;
   logic [N-1:0][3:0]  weight_bin;
   logic [N-1:0][7:0]  product_acc;
   logic               product_valid;
`ifdef SIMD_CELL_ADDER_TREE_EN
   logic [11:0]        dot_sum;
`endif

   always #5 clk = ~clk;

   simd_cell dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .input_bin     (input_bin),
      .weight_bin    (weight_bin),
      .product_acc   (product_acc),
      .product_valid (product_valid)
`ifdef SIMD_CELL_ADDER_TREE_EN
      ,
      .dot_sum       (dot_sum)
`endif
   );

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input int got, input int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, expv);
      end
   endfunction

   // ---------------- behavioural model ----------------
   int ph;
   int lat_in  [N];
   int lat_wt  [N];
   int exp_prod[N];
   bit exp_valid;
   int exp_dot;
   bit started = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         ph = 0; exp_valid = 0; exp_dot = 0;
         for (int i = 0; i < N; i++) begin
            exp_prod[i] = 0; lat_in[i] = 0; lat_wt[i] = 0;
         end
         started = 1'b1;
      end else if (!enable) begin
         ph = 0; exp_valid = 0;
      end else begin
         exp_valid = 0;
         if (ph == 0) begin
            for (int i = 0; i < N; i++) begin
               lat_in[i] = int'(input_bin[i]);
               lat_wt[i] = int'(weight_bin[i]);
            end
         end
         if (ph == 15) begin
            exp_dot = 0;
            for (int i = 0; i < N; i++) begin
               exp_prod[i] = (lat_in[i] * lat_wt[i]) % 256;
               exp_dot += exp_prod[i];
            end
            exp_valid = 1;
         end
         ph = (ph + 1) % 16;
      end
   end

   // Compare DUT with the model every cycle once reset has been applied.
   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < N; i++)
            chk($sformatf("model lane%0d", i), int'(product_acc[i]), exp_prod[i]);
         chk("model valid", int'(product_valid), int'(exp_valid));
`ifdef SIMD_CELL_ADDER_TREE_EN
         chk("model dot_sum", int'(dot_sum), exp_dot);
`endif
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_valid(input int maxc, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (product_valid !== 1'b1 && n < maxc);
      if (product_valid !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL valid_timeout: got no product_valid, expected one within %0d cycles", maxc);
      end
   endtask

   task automatic set_all(input int a, input int b);
      for (int i = 0; i < N; i++) begin
         input_bin[i]  = 4'(a);
         weight_bin[i] = 4'(b);
      end
   endtask

   task automatic chk_all(input string name, input int v);
      for (int i = 0; i < N; i++)
         chk($sformatf("%s lane%0d", name, i), int'(product_acc[i]), v);
   endtask

   int n;
   int in_t1 [N] = '{8, 7, 6, 5, 3, 2, 1, 0, 0};
   int exp_t1[N] = '{64, 49, 36, 25, 9, 4, 1, 0, 0};

   initial begin
      input_bin  = '0;
      weight_bin = '0;

      // Reset for 30 ns with enable low.
      repeat (3) @(negedge clk);
      chk_all("reset", 0);
      chk("reset valid", int'(product_valid), 0);
`ifdef SIMD_CELL_ADDER_TREE_EN
      chk("reset dot_sum", int'(dot_sum), 0);
`endif

      // Squares pattern.
      for (int i = 0; i < N; i++) begin
         input_bin[i]  = 4'(in_t1[i]);
         weight_bin[i] = 4'(in_t1[i]);
      end
      rst_n  = 1'b1;
      enable = 1'b1;
      wait_valid(20, n);
      chk("t1 latency", n, 16);
      for (int i = 0; i < N; i++)
         chk($sformatf("t1 lane%0d", i), int'(product_acc[i]), exp_t1[i]);
`ifdef SIMD_CELL_ADDER_TREE_EN
      chk("t1 dot_sum", int'(dot_sum), 188);
`endif

      // Maximum operands, then zero weight.
      set_all(15, 15);
      wait_valid(20, n);
      chk("t2 latency", n, 16);
      chk_all("t2 max", 225);
`ifdef SIMD_CELL_ADDER_TREE_EN
      chk("t2 dot_sum", int'(dot_sum), 2025);
`endif
      set_all(15, 0);
      wait_valid(20, n);
      chk_all("t2 zero", 0);
      @(negedge clk);
      chk("t2 pulse width", int'(product_valid), 0);

      // Abort at cnt 7: results must hold until a full new pass completes.
      for (int i = 0; i < N; i++) begin
         input_bin[i]  = 4'(i + 1);
         weight_bin[i] = 4'd3;
      end
      repeat (6) @(negedge clk);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      chk_all("t3 hold", 0);
      chk("t3 valid low", int'(product_valid), 0);
      enable = 1'b1;
      wait_valid(20, n);
      chk("t3 latency", n, 16);
      for (int i = 0; i < N; i++)
         chk($sformatf("t3 lane%0d", i), int'(product_acc[i]), 3 * (i + 1));
`ifdef SIMD_CELL_ADDER_TREE_EN
      chk("t3 dot_sum", int'(dot_sum), 135);
`endif

      // Operands change at cnt 5: current pass keeps the latched values.
      set_all(10, 12);
      repeat (5) @(negedge clk);
      set_all(13, 11);
      wait_valid(20, n);
      chk("t4 latency", n, 11);
      chk_all("t4 old", 120);
      wait_valid(20, n);
      chk_all("t4 new", 143);
`ifdef SIMD_CELL_ADDER_TREE_EN
      chk("t4 dot_sum", int'(dot_sum), 1287);
`endif

      // One-cycle reset mid-pass.
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_all("t5 reset", 0);
      chk("t5 reset valid", int'(product_valid), 0);
      rst_n = 1'b1;
      wait_valid(20, n);
      chk("t5 latency", n, 16);
      chk_all("t5 after", 143);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_simd_cell
`default_nettype wire
